// File: rtl/sd_host_pkg.sv
// sd_host_pkg: shared SD host constants, command FSM state encoding and default command width.
package sd_host_pkg;
  localparam int CMD_WIDTH = 6;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_REQ    = 2'd2;
  localparam logic [1:0] ST_BUSY   = 2'd3;
endpackage

// File: rtl/cmd_change_vec.sv
// cmd_change_vec: registers a vector every edge and flags any masked bit differing from last edge.
module cmd_change_vec
  import sd_host_pkg::*;
#(
  parameter int WIDTH = CMD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_vec,
  input  logic [WIDTH-1:0] i_mask,
  output logic             o_ch
);
  logic [WIDTH-1:0] r_last;
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_last <= '0;
    else r_last <= i_vec;
  assign o_ch = |((i_vec ^ r_last) & i_mask);
endmodule

// File: rtl/cmd_start_ctrl.sv
// cmd_start_ctrl: settles command register changes, issues a held start request with a command
// snapshot and tracks busy/pending/overrun. Define CMD_MASK_EN to add the change_mask port.
module cmd_start_ctrl
  import sd_host_pkg::*;
#(
  parameter int WIDTH  = CMD_WIDTH,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] command_register,
  input  logic             start_ack,
  input  logic             done,
  input  logic             overrun_clr,
`ifdef CMD_MASK_EN
  input  logic [WIDTH-1:0] change_mask,
`endif
  output logic             start_flag,
  output logic [WIDTH-1:0] start_cmd,
  output logic             busy,
  output logic             overrun
);
  localparam int CNT_W = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
  localparam logic [CNT_W:0] SETTLE_V = SETTLE[CNT_W:0];
  // With no settle window a change goes straight to the request state.
  localparam logic [1:0] ST_START = (SETTLE == 0) ? ST_REQ : ST_SETTLE;
  localparam logic       CAP_NOW  = (SETTLE == 0);
  logic [1:0]       r_state, w_nstate;
  logic [CNT_W-1:0] r_cnt, w_ncnt;
  logic [CNT_W:0]   w_cnt_inc;
  logic             r_pending, w_npend, r_overrun, w_set_ovr, w_cap, w_ch;
  logic [WIDTH-1:0] r_cmd, w_mask;
`ifdef CMD_MASK_EN
  assign w_mask = change_mask;
`else
  assign w_mask = '1;
`endif
  cmd_change_vec #(.WIDTH(WIDTH)) u_change (
    .clk    (clk),
    .reset  (reset),
    .i_vec  (command_register),
    .i_mask (w_mask),
    .o_ch   (w_ch)
  );
  assign w_cnt_inc = {1'b0, r_cnt} + 1'b1;
  always_comb begin
    w_nstate = r_state;
    w_ncnt   = r_cnt;
    w_npend  = r_pending;
    w_cap    = 1'b0;
    case (r_state)
      ST_IDLE:
        if (w_ch) begin
          w_nstate = ST_START;
          w_ncnt   = '0;
          w_cap    = CAP_NOW;
        end
      ST_SETTLE:
        if (w_ch) w_ncnt = '0;
        else if (w_cnt_inc == SETTLE_V) begin
          w_nstate = ST_REQ;
          w_cap    = 1'b1;
        end else w_ncnt = w_cnt_inc[CNT_W-1:0];
      ST_REQ: begin
        w_npend  = r_pending | w_ch;
        w_nstate = start_ack ? ST_BUSY : ST_REQ;
      end
      default:
        // A change on the done edge is folded into pending so it is not lost.
        if (done && (r_pending || w_ch)) begin
          w_npend  = 1'b0;
          w_nstate = ST_START;
          w_ncnt   = '0;
          w_cap    = CAP_NOW;
        end else if (done) w_nstate = ST_IDLE;
        else w_npend = r_pending | w_ch;
    endcase
  end
  assign w_set_ovr = w_ch & r_pending & r_state[1];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_pending <= 1'b0;
      r_overrun <= 1'b0;
      r_cmd     <= '0;
    end else begin
      r_state   <= w_nstate;
      r_cnt     <= w_ncnt;
      r_pending <= w_npend;
      r_overrun <= w_set_ovr ? 1'b1 : overrun_clr ? 1'b0 : r_overrun;
      r_cmd     <= w_cap ? command_register : r_cmd;
    end
  assign start_flag = (r_state == ST_REQ);
  assign busy       = (r_state == ST_REQ) || (r_state == ST_BUSY);
  assign start_cmd  = r_cmd;
  assign overrun    = r_overrun;
endmodule

// File: tb/tb_cmd_start_ctrl.sv
// tb_cmd_start_ctrl: directed plus random checks of cmd_start_ctrl against a behavioural model.
module tb_cmd_start_ctrl;
  localparam int W = 6;
  localparam int S = 2;
  logic clk = 0, reset = 1, ack = 0, done = 0, clr = 0;
  logic [W-1:0] cmd = '0;
`ifdef CMD_MASK_EN
  logic [W-1:0] mask = '1;
`endif
  logic start_flag, busy, overrun;
  logic [W-1:0] start_cmd;
  int checks = 0, errors = 0;
  bit cmp_en = 0;
  always #5 clk = ~clk;
  cmd_start_ctrl #(.WIDTH(W), .SETTLE(S)) dut (
    .clk              (clk),
    .reset            (reset),
    .command_register (cmd),
    .start_ack        (ack),
    .done             (done),
    .overrun_clr      (clr),
`ifdef CMD_MASK_EN
    .change_mask      (mask),
`endif
    .start_flag       (start_flag),
    .start_cmd        (start_cmd),
    .busy             (busy),
    .overrun          (overrun)
  );
  logic [W-1:0] m_last = '0, m_cmd = '0, mk;
  bit m_settling = 0, m_req = 0, m_busy = 0, m_pend = 0, m_over = 0;
  int m_stable = 0;
  bit ch, was_req, was_busy, was_pend, go, launch;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_last = '0; m_cmd = '0; m_settling = 0; m_req = 0; m_busy = 0;
      m_pend = 0; m_over = 0; m_stable = 0;
    end else begin
`ifdef CMD_MASK_EN
      mk = mask;
`else
      mk = '1;
`endif
      ch = ((cmd ^ m_last) & mk) != 0;
      m_last = cmd;
      was_req = m_req; was_busy = m_busy; was_pend = m_pend;
      go = 0; launch = 0;
      if (ch && (was_req || was_busy) && was_pend) m_over = 1;
      else if (clr) m_over = 0;
      if (m_settling) begin
        if (ch) m_stable = 0;
        else begin
          m_stable++;
          if (m_stable >= S) begin m_settling = 0; launch = 1; end
        end
      end else if (was_req) begin
        if (ch) m_pend = 1;
        if (ack) begin m_req = 0; m_busy = 1; end
      end else if (was_busy) begin
        if (done) begin
          m_busy = 0;
          if (was_pend || ch) begin m_pend = 0; go = 1; end
        end else if (ch) m_pend = 1;
      end else if (ch) go = 1;
      if (go) begin
        if (S == 0) launch = 1;
        else begin m_settling = 1; m_stable = 0; end
      end
      if (launch) begin m_req = 1; m_cmd = cmd; end
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) if (cmp_en) begin
    chk("model start_flag", 32'(start_flag), 32'(m_req));
    chk("model busy", 32'(busy), 32'(m_req || m_busy));
    chk("model start_cmd", 32'(start_cmd), 32'(m_cmd));
    chk("model overrun", 32'(overrun), 32'(m_over));
  end
  task automatic tick();
    @(negedge clk);
  endtask
  initial begin
    #1 reset = 0;
    #2 chk("reset start_flag", 32'(start_flag), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset start_cmd", 32'(start_cmd), 0);
    chk("reset overrun", 32'(overrun), 0);
    cmp_en = 1;
    tick(); tick(); reset = 1;
    repeat (3) begin tick(); chk("idle no start", 32'(start_flag), 0); chk("idle no busy", 32'(busy), 0); end
    cmd = 6'h11;
    tick(); chk("settle t", 32'(start_flag), 0);
    tick(); chk("settle t+1", 32'(start_flag), 0);
    tick(); chk("req t+2 flag", 32'(start_flag), 1); chk("req t+2 cmd", 32'(start_cmd), 32'h11);
    tick(); chk("req held t+3", 32'(start_flag), 1); ack = 1;
    tick(); ack = 0; chk("ack flag", 32'(start_flag), 0); chk("ack busy", 32'(busy), 1);
    done = 1;
    tick(); done = 0; chk("done busy", 32'(busy), 0);
    cmd = 6'h21;
    tick(); cmd = 6'h22;
    tick(); chk("restart t+1", 32'(start_flag), 0);
    tick(); chk("restart t+2", 32'(start_flag), 0);
    tick(); chk("restart req", 32'(start_flag), 1); chk("restart cmd", 32'(start_cmd), 32'h22);
    ack = 1;
    tick(); ack = 0; cmd = 6'h05;
    tick(); chk("pending no overrun", 32'(overrun), 0); cmd = 6'h06;
    tick(); chk("overrun set", 32'(overrun), 1); done = 1;
    tick(); done = 0; chk("pending resettle", 32'(busy), 0);
    tick();
    tick(); chk("pending req", 32'(start_flag), 1); chk("pending cmd", 32'(start_cmd), 32'h06);
    clr = 1;
    tick(); clr = 0; chk("overrun clr", 32'(overrun), 0);
    #2 reset = 0;
    #1 chk("async rst flag", 32'(start_flag), 0);
    chk("async rst busy", 32'(busy), 0);
    chk("async rst cmd", 32'(start_cmd), 0);
    cmd = 6'h11;
    tick(); reset = 1;
    tick(); tick();
    tick(); chk("post rst req", 32'(start_flag), 1); chk("post rst cmd", 32'(start_cmd), 32'h11);
    ack = 1; tick(); ack = 0; done = 1; tick(); done = 0;
`ifdef CMD_MASK_EN
    mask = 6'h3E; cmd = cmd ^ 6'h01;
    repeat (4) begin tick(); chk("masked bit no req", 32'(busy), 0); end
    cmd = cmd ^ 6'h08;
    tick(); tick();
    tick(); chk("unmasked req", 32'(start_flag), 1); chk("unmasked cmd", 32'(start_cmd), 32'(cmd));
    ack = 1; tick(); ack = 0; done = 1; tick(); done = 0; mask = '1;
`endif
    for (int i = 0; i < 3000; i++) begin
      tick();
      if ($urandom_range(0, 7) == 0) cmd = 6'($urandom);
      ack  = ($urandom_range(0, 2) == 0);
      done = ($urandom_range(0, 3) == 0);
      clr  = ($urandom_range(0, 15) == 0);
`ifdef CMD_MASK_EN
      if ($urandom_range(0, 31) == 0) mask = 6'($urandom);
`endif
      if ($urandom_range(0, 499) == 0) begin
        #2 reset = 0;
        tick(); reset = 1;
      end
    end
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cmd_start_ctrl.md
# cmd_start_ctrl

Parametrised command-start controller for the SD host. It watches the host-written command register for any bit change and qualifies the change with a settle window. It then issues a held start request with a snapshot of the command to the command FSM, and tracks busy, pending and overrun conditions until the FSM reports completion. It sits between the register file and the SD command/response engine.

## Interface
- WIDTH, 6, command register width (≥1)
- SETTLE, 2, consecutive stable cycles required before request (0 = request on first changed edge)
- CNT_W, derived $clog2(SETTLE+1) (min 1), settle counter width; not user-set
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- command_register  in  WIDTH  host command register contents
- start_ack  in  1  FSM accepts request; sampled only in REQ
- done  in  1  FSM finished command; sampled only in BUSY
- overrun_clr  in  1  clears sticky overrun
- change_mask  in  WIDTH  1 = bit participates in change detection (only with CMD_MASK_EN)
- start_flag  out  1  start request, held high until acknowledged
- start_cmd  out  WIDTH  command snapshot, stable from REQ entry until next capture
- busy  out  1  high in REQ or BUSY
- overrun  out  1  sticky: change arrived while one was already pending

## Operation
- last: WIDTH register, loads command_register every edge; reset 0.
- ch = |((command_register ^ last) & mask). mask is all-ones without the macro.
- States:
  - IDLE: ch → SETTLE, cnt=0 (SETTLE>0), or → REQ capturing start_cmd (SETTLE=0).
  - SETTLE: ch → cnt=0, stay. Otherwise cnt+1. When cnt+1 == SETTLE → REQ, capturing start_cmd = command_register.
  - REQ: start_ack → BUSY. ch → pending=1.
  - BUSY: ch → pending=1. done → if pending (or ch this edge): clear pending, go to SETTLE (cnt=0) or REQ with capture (SETTLE=0). Else → IDLE.
- Overrun: ch in REQ/BUSY while pending already 1 → overrun=1. overrun_clr clears it. If set and clear occur on the same edge, set wins.
- The count saturates at SETTLE; there is no wrap.
- start_flag = (state==REQ); busy = (state==REQ or BUSY); both registered-state decodes.
- After reset, last=0, so a nonzero command_register produces a start.

## Timing
- Reset values: start_flag 0, start_cmd 0, busy 0, overrun 0; state IDLE, last 0, pending 0, cnt 0.
- Reset acts immediately, mid-operation included. A request in flight is dropped with no pulse.
- SETTLE=0: command_register changes before edge t → start_flag high after edge t (1 edge latency).
- SETTLE=S, stable after change: SETTLE entered at edge t → start_flag high after edge t+S.
- start_ack high at edge e in REQ → start_flag low after e. Ack outside REQ is ignored.
- done in the same edge as a change in BUSY: the change counts as pending, so no request is lost.
- No combinational path from inputs to outputs.

## Configuration
- CMD_MASK_EN defined: change_mask port exists and masked bits never trigger. start_cmd still snapshots all WIDTH bits.
- Not defined: port absent; every bit triggers.

## Structure
- Shared package sd_host_pkg holds:
  - the state encoding (IDLE=0, SETTLE=1, REQ=2, BUSY=3, 2-bit)
  - the default WIDTH constant for the command register
- Sub-module cmd_change_vec holds the last register, XOR and mask, and outputs ch. It is reusable for other register-change triggers.

## Test plan
All cases use WIDTH=6, SETTLE=2.
- Reset release with command_register=0x00, held → start_flag stays 0 and busy stays 0.
- Write 0x11, hold → SETTLE entered at edge t. start_flag=1 and start_cmd=0x11 after t+2. Ack at t+4 → start_flag=0, busy=1. done → busy=0.
- Write 0x11, then 0x12 one edge later → settle restarts. Request after 2 more stable edges with start_cmd=0x12.
- In BUSY, write 0x05, then 0x06 → pending=1 then overrun=1. done → new request with start_cmd=0x06. overrun_clr → overrun=0.
- CMD_MASK_EN, change_mask=0x3E, toggle bit 0 only → no request. Toggle bit 3 → request.
- Assert reset while in REQ → start_flag, busy and start_cmd are 0 immediately. After release with 0x11 present → new request.
